// File: rtl/data_mem_ctrl.sv
module data_mem_ctrl #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  input  logic [1:0]        ReqBHW,
  input  logic              ReqSigned,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspErr
);

  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned OFF_W    = $clog2(NB);
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("data_mem_ctrl: DATA_W must be 32 or 64");
  end
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_ctrl: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              accept;
  logic              wr_en;
  logic [OFF_W-1:0]  lane;
  logic [ADDR_W-1:0] idx_full;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        nbytes;
  logic              err_align;
  logic              err_range;
  logic              err_size;
  logic              req_err;

  assign lane      = ReqAddr[OFF_W-1:0];
  assign idx_full  = ReqAddr >> OFF_W;
  assign idx       = idx_full[IDX_W-1:0];
  assign nbytes    = 4'd1 << ReqBHW;
  assign err_align = (4'(lane) & (nbytes - 4'd1)) != 4'd0;
  assign err_range = idx_full >= ADDR_W'(DEPTH);
  assign err_size  = (ReqBHW == 2'd3) && (DATA_W == 32);
  assign req_err   = err_align | err_range | err_size;

  assign accept    = ReqValid && ReqReady;
  assign wr_en     = accept && ReqWrite && !req_err;

  logic [DATA_W-1:0] rd_entry;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] wdata_sh;
  logic [NB-1:0]     be;
  logic [7:0]        byte_v;
  logic              sign;

  assign rd_entry = mem[idx];
  assign rd_shift = rd_entry >> {lane, 3'b000};
  assign wdata_sh = ReqWData << {lane, 3'b000};

  always_comb begin
    mask   = '0;
    be     = '0;
    byte_v = '0;
    sign   = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < 32'(nbytes)) begin
        mask[i*8 +: 8] = 8'hFF;
      end
      if (i == 32'(nbytes) - 1) begin
        byte_v = rd_shift[i*8 +: 8];
        sign   = byte_v[7];
      end
      if (i >= 32'(lane) && i < 32'(lane) + 32'(nbytes)) begin
        be[i] = 1'b1;
      end
    end
  end

  assign ld_val = (rd_shift & mask) | ((ReqSigned && sign) ? ~mask : '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  logic [3:0] cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (RspReady)    state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ReqReady = 1'b0;
    RspValid = 1'b0;
    case (state)
      IDLE:    ReqReady = !Reset;
      RESP:    RspValid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rsp_err  <= req_err;
      rsp_data <= (req_err || ReqWrite) ? '0 : ld_val;
    end
  end

  assign RspData = rsp_data;
  assign RspErr  = rsp_err;

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Directed bench for data_mem_ctrl with default parameters
//   (DATA_W=64, DEPTH=256, ADDR_W=64, LATENCY=2).
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

    logic        Clk;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [63:0] ReqAddr;
    logic [63:0] ReqWData;
    logic [1:0]  ReqBHW;
    logic        ReqSigned;
    logic        RspValid;
    logic        RspReady;
    logic [63:0] RspData;
    logic        RspErr;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    data_mem_ctrl #(
        .DATA_W (64),
        .DEPTH  (256),
        .ADDR_W (64),
        .LATENCY(2)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqWrite (ReqWrite),
        .ReqAddr  (ReqAddr),
        .ReqWData (ReqWData),
        .ReqBHW   (ReqBHW),
        .ReqSigned(ReqSigned),
        .RspValid (RspValid),
        .RspReady (RspReady),
        .RspData  (RspData),
        .RspErr   (RspErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request from IDLE (called #1 after a rising edge), scrambles
    // the request inputs after accept, checks the 2-cycle latency and returns
    // with the DUT in RESP, sampled #1 after the edge that raised RspValid.
    task automatic do_req(input string tag, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [1:0] bhw, input logic sgn,
                          output logic [63:0] d, output logic e);
        check({tag, ":ready"}, 64'(ReqReady), 64'd1);
        ReqValid  = 1'b1;
        ReqWrite  = wr;
        ReqAddr   = addr;
        ReqWData  = wd;
        ReqBHW    = bhw;
        ReqSigned = sgn;
        @(posedge Clk); #1;
        ReqValid  = 1'b0;
        ReqWrite  = ~wr;
        ReqAddr   = ~addr;
        ReqWData  = ~wd;
        ReqBHW    = ~bhw;
        ReqSigned = ~sgn;
        check({tag, ":lat1"}, 64'(RspValid), 64'd0);
        @(posedge Clk); #1;
        check({tag, ":lat2"}, 64'(RspValid), 64'd0);
        @(posedge Clk); #1;
        check({tag, ":valid"}, 64'(RspValid), 64'd1);
        d = RspData;
        e = RspErr;
    endtask

    // Completes the handshake (RspReady must be 1) and confirms IDLE.
    task automatic finish_rsp(input string tag);
        @(posedge Clk); #1;
        check({tag, ":done"}, 64'(RspValid), 64'd0);
        check({tag, ":idle"}, 64'(ReqReady), 64'd1);
    endtask

    initial begin
        logic [63:0] d;
        logic        e;

        Reset     = 1'b1;
        ReqValid  = 1'b0;
        ReqWrite  = 1'b0;
        ReqAddr   = '0;
        ReqWData  = '0;
        ReqBHW    = 2'd0;
        ReqSigned = 1'b0;
        RspReady  = 1'b1;

        // Reset state
        @(posedge Clk); #1;
        check("rst:ReqReady", 64'(ReqReady), 64'd0);
        check("rst:RspValid", 64'(RspValid), 64'd0);
        check("rst:RspData",  RspData,       64'd0);
        check("rst:RspErr",   64'(RspErr),   64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("rst:ReqReady_after", 64'(ReqReady), 64'd1);

        // Doubleword store then load
        do_req("st_d", 1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, d, e);
        check("st_d:data", d, 64'd0);
        check("st_d:err",  64'(e), 64'd0);
        finish_rsp("st_d");

        do_req("ld_d", 1'b0, 64'h10, 64'h0, 2'd3, 1'b0, d, e);
        check("ld_d:data", d, 64'h1122334455667788);
        check("ld_d:err",  64'(e), 64'd0);
        finish_rsp("ld_d");

        // Byte store into lane 3 of entry 2
        do_req("st_b", 1'b1, 64'h13, 64'hFFFFFFFFFFFFFFAB, 2'd0, 1'b0, d, e);
        check("st_b:err", 64'(e), 64'd0);
        finish_rsp("st_b");

        do_req("ld_entry2", 1'b0, 64'h10, 64'h0, 2'd3, 1'b1, d, e);
        check("ld_entry2:data", d, 64'h11223344AB667788);
        finish_rsp("ld_entry2");

        // Signed / unsigned loads
        do_req("ld_sb", 1'b0, 64'h13, 64'h0, 2'd0, 1'b1, d, e);
        check("ld_sb:data", d, 64'hFFFFFFFFFFFFFFAB);
        check("ld_sb:err",  64'(e), 64'd0);
        finish_rsp("ld_sb");

        do_req("ld_ub", 1'b0, 64'h13, 64'h0, 2'd0, 1'b0, d, e);
        check("ld_ub:data", d, 64'h00000000000000AB);
        finish_rsp("ld_ub");

        do_req("ld_sh14", 1'b0, 64'h14, 64'h0, 2'd1, 1'b1, d, e);
        check("ld_sh14:data", d, 64'h0000000000003344);
        finish_rsp("ld_sh14");

        do_req("ld_sh12", 1'b0, 64'h12, 64'h0, 2'd1, 1'b1, d, e);
        check("ld_sh12:data", d, 64'hFFFFFFFFFFFFAB66);
        finish_rsp("ld_sh12");

        do_req("ld_uw", 1'b0, 64'h10, 64'h0, 2'd2, 1'b0, d, e);
        check("ld_uw:data", d, 64'h00000000AB667788);
        finish_rsp("ld_uw");

        do_req("ld_sw", 1'b0, 64'h10, 64'h0, 2'd2, 1'b1, d, e);
        check("ld_sw:data", d, 64'hFFFFFFFFAB667788);
        finish_rsp("ld_sw");

        // Error cases
        do_req("st_w_mis", 1'b1, 64'h12, 64'hDEADBEEF, 2'd2, 1'b0, d, e);
        check("st_w_mis:err",  64'(e), 64'd1);
        check("st_w_mis:data", d, 64'd0);
        finish_rsp("st_w_mis");

        do_req("ld_unchanged", 1'b0, 64'h10, 64'h0, 2'd3, 1'b0, d, e);
        check("ld_unchanged:data", d, 64'h11223344AB667788);
        check("ld_unchanged:err",  64'(e), 64'd0);
        finish_rsp("ld_unchanged");

        do_req("ld_oor", 1'b0, 64'h800, 64'h0, 2'd3, 1'b0, d, e);
        check("ld_oor:err",  64'(e), 64'd1);
        check("ld_oor:data", d, 64'd0);
        finish_rsp("ld_oor");

        do_req("ld_h_mis", 1'b0, 64'h11, 64'h0, 2'd1, 1'b0, d, e);
        check("ld_h_mis:err",  64'(e), 64'd1);
        check("ld_h_mis:data", d, 64'd0);
        finish_rsp("ld_h_mis");

        // Backpressure: response held, competing store not accepted
        do_req("bp", 1'b0, 64'h10, 64'h0, 2'd3, 1'b0, d, e);
        check("bp:data", d, 64'h11223344AB667788);
        RspReady  = 1'b0;
        ReqValid  = 1'b1;
        ReqWrite  = 1'b1;
        ReqAddr   = 64'h10;
        ReqWData  = 64'h0;
        ReqBHW    = 2'd3;
        ReqSigned = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            check("bp:hold_valid", 64'(RspValid), 64'd1);
            check("bp:hold_data",  RspData,       64'h11223344AB667788);
            check("bp:hold_err",   64'(RspErr),   64'd0);
            check("bp:hold_ready", 64'(ReqReady), 64'd0);
        end
        ReqValid = 1'b0;
        RspReady = 1'b1;
        finish_rsp("bp");

        do_req("bp_nostore", 1'b0, 64'h10, 64'h0, 2'd3, 1'b0, d, e);
        check("bp_nostore:data", d, 64'h11223344AB667788);
        finish_rsp("bp_nostore");

        // Reset while waiting: response dropped, accepted store kept
        ReqValid  = 1'b1;
        ReqWrite  = 1'b1;
        ReqAddr   = 64'h20;
        ReqWData  = 64'hCAFEF00D12345678;
        ReqBHW    = 2'd3;
        ReqSigned = 1'b0;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        Reset    = 1'b1;
        #1;
        check("rstw:valid",    64'(RspValid), 64'd0);
        check("rstw:ready",    64'(ReqReady), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            check("rstw:valid_held", 64'(RspValid), 64'd0);
        end
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("rstw:valid_after", 64'(RspValid), 64'd0);
        check("rstw:ready_after", 64'(ReqReady), 64'd1);

        do_req("rstw_ld", 1'b0, 64'h20, 64'h0, 2'd3, 1'b0, d, e);
        check("rstw_ld:data", d, 64'hCAFEF00D12345678);
        check("rstw_ld:err",  64'(e), 64'd0);
        finish_rsp("rstw_ld");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
